// File: rtl/axi4_lite_Defs.sv
// ---------------------------------------------------------------------------
// axi4_lite_Defs
// Shared definitions for the AXI4-Lite register file:
//   - default bus address / data widths
//   - AXI response encodings
//   - write- and read-channel FSM state types
// ---------------------------------------------------------------------------
package axi4_lite_Defs;

  localparam int Addr_Width = 32;
  localparam int Data_Width = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Write channel: ADDR = address held waiting for data,
  //                DATA = data held waiting for address.
  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_e;

endpackage

// File: rtl/axi4_lite_strb_merge.sv
// ---------------------------------------------------------------------------
// axi4_lite_strb_merge
// Combinational byte-lane merge: lane b of the result is new_i where
// strb_i[b] is set, otherwise old_i.
// Ports:
//   old_i    [DATA_WIDTH-1:0]   current register contents
//   new_i    [DATA_WIDTH-1:0]   incoming write data
//   strb_i   [DATA_WIDTH/8-1:0] byte-lane strobes
//   merged_o [DATA_WIDTH-1:0]   merged value
// ---------------------------------------------------------------------------
module axi4_lite_strb_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_i,
  input  logic [DATA_WIDTH-1:0]   new_i,
  input  logic [DATA_WIDTH/8-1:0] strb_i,
  output logic [DATA_WIDTH-1:0]   merged_o
);

  for (genvar gi = 0; gi < DATA_WIDTH / 8; gi++) begin : g_lane
    assign merged_o[gi*8 +: 8] = strb_i[gi] ? new_i[gi*8 +: 8] : old_i[gi*8 +: 8];
  end

endmodule

// File: rtl/axi4_lite_slave_regfile.sv
// ---------------------------------------------------------------------------
// axi4_lite_slave_regfile
// AXI4-Lite slave exposing NUM_REGS registers of DATA_WIDTH bits. Registers
// flagged in RO_MASK are read-only and reflect the matching ro_in lane.
// Write and read channels run independent FSMs.
// Ports:
//   ACLK, ARESETN                 clock, asynchronous active-low reset
//   AW*/W*/B*                     AXI4-Lite write address/data/response
//   AR*/R*                        AXI4-Lite read address/data
//   reg_q  [NUM_REGS*DATA_WIDTH]  register contents, reg i at [i*DW +: DW]
//   ro_in  [NUM_REGS*DATA_WIDTH]  hardware values for read-only slots
// ---------------------------------------------------------------------------
module axi4_lite_slave_regfile
  import axi4_lite_Defs::*;
#(
  parameter int                    ADDR_WIDTH = Addr_Width,
  parameter int                    DATA_WIDTH = Data_Width,
  parameter int                    NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_in
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_BITS = $clog2(NUM_REGS);
  // A single register still needs a 1-bit index so slices stay legal; that
  // bit then lies in the "high" field and is range-checked there.
  localparam int IDX_W    = (IDX_BITS > 0) ? IDX_BITS : 1;
  // Slot table is padded to a power of two so any index value is a legal
  // array reference; padding slots read as zero and are rejected by decode.
  localparam int SLOTS    = 1 << IDX_W;
  localparam int HI_LSB   = ADDR_LSB + IDX_BITS;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  wr_state_e w_state_q, w_state_d;
  rd_state_e r_state_q, r_state_d;

  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic [1:0]            bresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;

  logic [DATA_WIDTH-1:0] slot_val [SLOTS];
  logic [SLOTS-1:0]      slot_ro;

  // -------------------------------------------------------------------------
  // Write path: the effective address/data come from the holding registers
  // when that half arrived earlier, otherwise straight from the bus.
  // -------------------------------------------------------------------------
  logic                  aw_hs, w_hs, wr_commit;
  logic [ADDR_WIDTH-1:0] wr_addr_eff;
  logic [DATA_WIDTH-1:0] wr_data_eff;
  logic [STRB_W-1:0]     wr_strb_eff;
  logic [IDX_W-1:0]      wr_idx;
  logic                  wr_in_range, wr_ok;

  assign aw_hs = AWVALID & AWREADY;
  assign w_hs  = WVALID & WREADY;

  // Commit on the edge completing the second of the two handshakes.
  assign wr_commit = ((w_state_q == W_IDLE) & aw_hs & w_hs) |
                     ((w_state_q == W_ADDR) & w_hs) |
                     ((w_state_q == W_DATA) & aw_hs);

  assign wr_addr_eff = (w_state_q == W_ADDR) ? awaddr_q : AWADDR;
  assign wr_data_eff = (w_state_q == W_DATA) ? wdata_q  : WDATA;
  assign wr_strb_eff = (w_state_q == W_DATA) ? wstrb_q  : WSTRB;

  assign wr_idx      = wr_addr_eff[ADDR_LSB +: IDX_W];
  assign wr_in_range = ((wr_addr_eff >> HI_LSB) == '0) && (32'(wr_idx) < NUM_REGS);
  assign wr_ok       = wr_in_range && !slot_ro[wr_idx];

  // -------------------------------------------------------------------------
  // Read decode
  // -------------------------------------------------------------------------
  logic             ar_hs;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_in_range;

  assign ar_hs       = ARVALID & ARREADY;
  assign rd_idx      = ARADDR[ADDR_LSB +: IDX_W];
  assign rd_in_range = ((ARADDR >> HI_LSB) == '0) && (32'(rd_idx) < NUM_REGS);

  // Sub-word address bits and ro_in lanes of writable slots are don't-care.
  logic unused_sink;
  assign unused_sink = ^{wr_addr_eff, ARADDR, ro_in};

  // -------------------------------------------------------------------------
  // Register slots
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
    if (gi < NUM_REGS) begin : g_used
      if (RO_MASK[gi]) begin : g_ro
        // Read-only: mirrors the hardware input with no storage.
        assign slot_val[gi] = ro_in[gi*DATA_WIDTH +: DATA_WIDTH];
        assign slot_ro[gi]  = 1'b1;
      end else begin : g_rw
        logic [DATA_WIDTH-1:0] data_q;
        logic [DATA_WIDTH-1:0] merged;

        axi4_lite_strb_merge #(
          .DATA_WIDTH(DATA_WIDTH)
        ) u_merge (
          .old_i   (data_q),
          .new_i   (wr_data_eff),
          .strb_i  (wr_strb_eff),
          .merged_o(merged)
        );

        always_ff @(posedge ACLK or negedge ARESETN) begin
          if (!ARESETN) begin
            data_q <= RESET_VAL;
          end else if (wr_commit && wr_ok && (wr_idx == IDX_W'(gi))) begin
            data_q <= merged;
          end
        end

        assign slot_val[gi] = data_q;
        assign slot_ro[gi]  = 1'b0;
      end
      assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = slot_val[gi];
    end else begin : g_pad
      assign slot_val[gi] = '0;
      assign slot_ro[gi]  = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Write FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state_q <= W_IDLE;
    end else begin
      w_state_q <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    AWREADY   = 1'b0;
    WREADY    = 1'b0;
    BVALID    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        AWREADY = ARESETN;
        WREADY  = ARESETN;
        if (AWVALID && WVALID) begin
          w_state_d = W_RESP;
        end else if (AWVALID) begin
          w_state_d = W_ADDR;
        end else if (WVALID) begin
          w_state_d = W_DATA;
        end
      end
      W_ADDR: begin
        WREADY = ARESETN;
        if (WVALID) begin
          w_state_d = W_RESP;
        end
      end
      W_DATA: begin
        AWREADY = ARESETN;
        if (AWVALID) begin
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        BVALID = 1'b1;
        if (BREADY) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Holding registers for whichever half arrives first, plus the response.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= RESP_OKAY;
    end else begin
      if ((w_state_q == W_IDLE) && aw_hs) begin
        awaddr_q <= AWADDR;
      end
      if ((w_state_q == W_IDLE) && w_hs) begin
        wdata_q <= WDATA;
        wstrb_q <= WSTRB;
      end
      if (wr_commit) begin
        bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign BRESP = bresp_q;

  // -------------------------------------------------------------------------
  // Read FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state_q <= R_IDLE;
    end else begin
      r_state_q <= r_state_d;
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    ARREADY   = 1'b0;
    RVALID    = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        ARREADY = ARESETN;
        if (ARVALID) begin
          r_state_d = R_RESP;
        end
      end
      R_RESP: begin
        RVALID = 1'b1;
        if (RREADY) begin
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Captures the slot value as it is before any same-edge write commit, so
  // a colliding read returns the pre-write contents.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_q <= rd_in_range ? slot_val[rd_idx] : '0;
      rresp_q <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign RDATA = rdata_q;
  assign RRESP = rresp_q;

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
module tb_axi4_lite_slave_regfile;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 8;

  logic           ACLK = 1'b0;
  logic           ARESETN;
  logic [AW-1:0]  AWADDR;
  logic           AWVALID;
  logic           AWREADY;
  logic [DW-1:0]  WDATA;
  logic [DW/8-1:0] WSTRB;
  logic           WVALID;
  logic           WREADY;
  logic [1:0]     BRESP;
  logic           BVALID;
  logic           BREADY;
  logic [AW-1:0]  ARADDR;
  logic           ARVALID;
  logic           ARREADY;
  logic [DW-1:0]  RDATA;
  logic [1:0]     RRESP;
  logic           RVALID;
  logic           RREADY;
  logic [NR*DW-1:0] reg_q;
  logic [NR*DW-1:0] ro_in;

  int checks   = 0;
  int failures = 0;

  axi4_lite_slave_regfile #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .NUM_REGS  (NR),
    .RO_MASK   (8'h80),
    .RESET_VAL (32'h0)
  ) dut (
    .ACLK   (ACLK),
    .ARESETN(ARESETN),
    .AWADDR (AWADDR),
    .AWVALID(AWVALID),
    .AWREADY(AWREADY),
    .WDATA  (WDATA),
    .WSTRB  (WSTRB),
    .WVALID (WVALID),
    .WREADY (WREADY),
    .BRESP  (BRESP),
    .BVALID (BVALID),
    .BREADY (BREADY),
    .ARADDR (ARADDR),
    .ARVALID(ARVALID),
    .ARREADY(ARREADY),
    .RDATA  (RDATA),
    .RRESP  (RRESP),
    .RVALID (RVALID),
    .RREADY (RREADY),
    .reg_q  (reg_q),
    .ro_in  (ro_in)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_aw();
    int n = 0;
    while (!AWREADY && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    chk("awready_wait", n < 20, 1'b1);
    @(negedge ACLK);
    AWVALID = 1'b0;
  endtask

  task automatic wait_w();
    int n = 0;
    while (!WREADY && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    chk("wready_wait", n < 20, 1'b1);
    @(negedge ACLK);
    WVALID = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int lead, input bit accept,
                          output logic bv, output logic [1:0] br);
    int n;
    AWADDR = addr;
    WDATA  = data;
    WSTRB  = strb;
    if (lead == 0) begin
      AWVALID = 1'b1;
      WVALID  = 1'b1;
      n = 0;
      while (!(AWREADY && WREADY) && n < 20) begin
        @(negedge ACLK);
        n++;
      end
      chk("wr_ready_wait", n < 20, 1'b1);
      @(negedge ACLK);
      AWVALID = 1'b0;
      WVALID  = 1'b0;
    end else if (lead > 0) begin
      WVALID = 1'b1;
      wait_w();
      repeat (lead - 1) @(negedge ACLK);
      AWVALID = 1'b1;
      wait_aw();
    end else begin
      AWVALID = 1'b1;
      wait_aw();
      repeat (-lead - 1) @(negedge ACLK);
      WVALID = 1'b1;
      wait_w();
    end
    bv = BVALID;
    br = BRESP;
    $display("WRITE addr=%08h data=%08h strb=%0h bvalid=%0b bresp=%0b", addr, data, strb, bv, br);
    if (accept) begin
      BREADY = 1'b1;
      @(negedge ACLK);
      BREADY = 1'b0;
    end
  endtask

  task automatic do_read(input logic [31:0] addr, output logic rv,
                         output logic [31:0] rd, output logic [1:0] rr);
    int n = 0;
    ARADDR  = addr;
    ARVALID = 1'b1;
    while (!ARREADY && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    chk("arready_wait", n < 20, 1'b1);
    @(negedge ACLK);
    ARVALID = 1'b0;
    rv = RVALID;
    rd = RDATA;
    rr = RRESP;
    $display("READ  addr=%08h rvalid=%0b rdata=%08h rresp=%0b", addr, rv, rd, rr);
    RREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0;
  endtask

  logic        bv, rv;
  logic [1:0]  br, rr;
  logic [31:0] rd;
  logic [NR*DW-1:0] exp_regs;

  initial begin
    ARESETN = 1'b1;
    AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
    BREADY = 1'b0; ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;
    ro_in = {32'hCAFEF00D, {7{32'hBAD0BAD0}}};
    #2 ARESETN = 1'b0;

    repeat (2) @(negedge ACLK);
    chk("rst_awready", AWREADY, 1'b0);
    chk("rst_wready", WREADY, 1'b0);
    chk("rst_arready", ARREADY, 1'b0);
    chk("rst_bvalid", BVALID, 1'b0);
    chk("rst_rvalid", RVALID, 1'b0);
    chk("rst_bresp", BRESP, 2'b00);
    chk("rst_rresp", RRESP, 2'b00);
    chk("rst_rdata", RDATA, 32'h0);
    ARESETN = 1'b1;
    @(negedge ACLK);
    chk("idle_awready", AWREADY, 1'b1);
    chk("idle_arready", ARREADY, 1'b1);
    exp_regs = {32'hCAFEF00D, 224'h0};
    chk("rst_reg_q", reg_q, exp_regs);

    do_read(32'h0C, rv, rd, rr);
    chk("rd3_rvalid", rv, 1'b1);
    chk("rd3_rdata", rd, 32'h0);
    chk("rd3_rresp", rr, 2'b00);

    do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 1'b0, bv, br);
    chk("wr1_bvalid", bv, 1'b1);
    chk("wr1_bresp", br, 2'b00);
    chk("wr1_reg_q", reg_q[63:32], 32'hDEADBEEF);
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;

    do_write(32'h04, 32'h11223344, 4'b0101, 3, 1'b1, bv, br);
    chk("wr1b_bvalid", bv, 1'b1);
    chk("wr1b_bresp", br, 2'b00);
    do_read(32'h04, rv, rd, rr);
    chk("rd1_rdata", rd, 32'hDE22BE44);

    do_write(32'h08, 32'h01020304, 4'hF, -2, 1'b1, bv, br);
    chk("wr2_bresp", br, 2'b00);
    do_read(32'h08, rv, rd, rr);
    chk("rd2_rdata", rd, 32'h01020304);

    exp_regs = {32'hCAFEF00D, 96'h0, 32'h0, 32'h01020304, 32'hDE22BE44, 32'h0};
    do_write(32'h40, 32'hFFFFFFFF, 4'hF, 0, 1'b1, bv, br);
    chk("wr_oor_bresp", br, 2'b10);
    chk("wr_oor_nochange", reg_q, exp_regs);
    do_read(32'h40, rv, rd, rr);
    chk("rd_oor_rdata", rd, 32'h0);
    chk("rd_oor_rresp", rr, 2'b10);

    do_write(32'h1C, 32'h55555555, 4'hF, 0, 1'b1, bv, br);
    chk("wr_ro_bresp", br, 2'b10);
    chk("wr_ro_nochange", reg_q, exp_regs);
    do_read(32'h1C, rv, rd, rr);
    chk("rd_ro_rdata", rd, 32'hCAFEF00D);
    chk("rd_ro_rresp", rr, 2'b00);
    ro_in[255:224] = 32'h13579BDF;
    #1;
    chk("ro_mirror", reg_q[255:224], 32'h13579BDF);
    ro_in[255:224] = 32'hCAFEF00D;

    do_write(32'h0E, 32'hA5A5A5A5, 4'hF, 0, 1'b1, bv, br);
    chk("wr_mis_bresp", br, 2'b00);
    do_read(32'h0C, rv, rd, rr);
    chk("rd_mis_rdata", rd, 32'hA5A5A5A5);
    do_write(32'h0C, 32'hFFFFFFFF, 4'h0, 0, 1'b1, bv, br);
    chk("wr_strb0_bresp", br, 2'b00);
    chk("wr_strb0_reg3", reg_q[127:96], 32'hA5A5A5A5);

    AWADDR = 32'h0C; WDATA = 32'h5A5A5A5A; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1; ARADDR = 32'h0C; ARVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    $display("COLLIDE addr=0000000c rvalid=%0b rdata=%08h bvalid=%0b", RVALID, RDATA, BVALID);
    chk("coll_rvalid", RVALID, 1'b1);
    chk("coll_bvalid", BVALID, 1'b1);
    chk("coll_rdata", RDATA, 32'hA5A5A5A5);
    chk("coll_reg3", reg_q[127:96], 32'h5A5A5A5A);
    BREADY = 1'b1; RREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0; RREADY = 1'b0;

    do_write(32'h00, 32'h12345678, 4'hF, 0, 1'b1, bv, br);
    chk("wr0_reg_q", reg_q[31:0], 32'h12345678);
    do_write(32'h1C, 32'h0, 4'hF, 0, 1'b0, bv, br);
    chk("stall_first_bvalid", bv, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge ACLK);
      chk("stall_bvalid", BVALID, 1'b1);
      chk("stall_bresp", BRESP, 2'b10);
      chk("stall_awready", AWREADY, 1'b0);
      chk("stall_wready", WREADY, 1'b0);
    end

    #2 ARESETN = 1'b0;
    #1;
    chk("arst_bvalid", BVALID, 1'b0);
    chk("arst_awready", AWREADY, 1'b0);
    chk("arst_reg0", reg_q[31:0], 32'h0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    exp_regs = {32'hCAFEF00D, 224'h0};
    chk("arst_reg_q", reg_q, exp_regs);
    chk("arst_bresp", BRESP, 2'b00);
    do_read(32'h04, rv, rd, rr);
    chk("arst_rd1", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
